uart_frame_scheduler: RTL and testbench
=======================================

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: maximum cycles to wait for tx_busy rise after a tx_start pulse.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester has a word pending.
REQ-006 SHALL have ports req0_data / req1_data, input, 32 each: payload words, held stable while valid and not ready.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each: one-cycle acceptance strobe; the word transfers when valid and ready are both high.
REQ-008 SHALL have port tx_data, output, 8: byte to the UART transmitter's data_in.
REQ-009 SHALL have port tx_start, output, 1: one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_busy, input, 1: UART transmitter busy flag; rises the cycle after an accepted start.
REQ-011 SHALL have port frame_busy, output, 1: high from acceptance until the last byte completes.
REQ-012 SHALL have port err_timeout, output, 1: sticky; set on any accept timeout and cleared only by reset.

Function
REQ-013 SHALL send each frame as 7 bytes: SYNC_BYTE, source ID (8'h00 or 8'h01), data[31:24], data[23:16], data[15:8], data[7:0], then checksum.
REQ-014 SHALL compute checksum as the 8-bit XOR of bytes 2-6 (ID and payload); SYNC_BYTE is excluded.
REQ-015 SHALL use states IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT.
REQ-016 IDLE: if any valid, SHALL grant one requester, pulse its ready, latch its ID and data, and go to LOAD.
REQ-017 Arbitration SHALL be round-robin over 2: after reset priority favours req0; after each grant priority moves to the other requester; a lone valid is always granted.
REQ-018 LOAD: SHALL set byte index to 0, place byte 0 on tx_data, and go to START.
REQ-019 START: SHALL assert tx_start for exactly one cycle, with tx_data stable, only when tx_busy=0; SHALL then go to WAIT_ACK.
REQ-020 WAIT_ACK: on tx_busy=1 SHALL go to WAIT_DONE.
REQ-021 WAIT_ACK timeout: after ACK_TIMEOUT cycles without tx_busy, SHALL set err_timeout and return to START to re-pulse the same byte.
REQ-022 WAIT_DONE: on tx_busy=0 SHALL go to NEXT.
REQ-023 NEXT: if byte index = 6, SHALL go to IDLE with frame_busy low; otherwise SHALL increment the index, present the next byte, and go to START.
REQ-024 Minimum gap from tx_busy fall to the next tx_start SHALL be 2 cycles (NEXT, START).
REQ-025 Bytes of one frame SHALL never interleave with another frame.
REQ-026 Requests arriving mid-frame SHALL wait without being lost.
REQ-027 ready SHALL never be asserted outside IDLE.
REQ-028 Checksum SHALL accumulate at grant time from the latched data, not from the live inputs.
REQ-029 Simultaneous valids SHALL resolve by the priority pointer only; the loser's ready stays low.

Reset
REQ-030 rst=0 at a clock edge SHALL force: IDLE, tx_start=0, tx_data=8'h00, ready outputs 0, frame_busy=0, err_timeout=0, priority=req0, byte index=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no further tx_start; the UART transmitter is reset by the same system reset.

Structure
REQ-032 A shared package SHALL hold the state enumeration, FRAME_LEN=7, the ID constants, and the SYNC_BYTE default.
REQ-033 One sub-module, rr_arbiter2 (2-way round-robin grant with priority pointer), SHALL be instantiated; the byte mux and checksum stay inline.

Verification
REQ-034 req0 valid, data 32'h12345678; UART model answers busy after 1 cycle -> tx bytes A5,00,12,34,56,78,08; req0_ready pulses once; frame_busy high throughout.
REQ-035 Both valid on the same cycle after reset, req0=32'h0, req1=32'hFFFFFFFF -> first frame ID 00 (checksum 00), second frame ID 01 (checksum 01); no interleave.
REQ-036 req0 held valid continuously and req1 asserted mid-frame -> the next frame is req1, then req0 again (alternation).
REQ-037 UART model ignores the first tx_start -> after 15 cycles err_timeout=1 and tx_start is re-pulsed with the same byte (A5); the frame then completes normally.
REQ-038 rst=0 during byte 3 -> next edge: tx_start=0, frame_busy=0, ready=0; after release a new req1 frame starts with A5,01.

Source files
------------

// File: rtl/uart_frame_scheduler_pkg.sv
// rtl/uart_frame_scheduler_pkg.sv - shared constants, FSM encodings and checksum helper
package uart_frame_scheduler_pkg;

    localparam int         FRAME_LEN         = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] ID_REQ0           = 8'h00;
    localparam logic [7:0] ID_REQ1           = 8'h01;

    typedef logic [2:0] byte_idx_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_NEXT      = 3'd5;

    // Sync byte is deliberately left out of the checksum.
    function automatic logic [7:0] frame_checksum(input logic [7:0] id, input logic [31:0] data);
        return id ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// rtl/uart_frame_scheduler_if.sv - requester handshakes and UART transmitter link
interface uart_frame_scheduler_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic        req0_ready;
    logic        req1_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        frame_busy;
    logic        err_timeout;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_data, tx_start, frame_busy, err_timeout
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_data, tx_start, frame_busy, err_timeout
    );
endinterface

// File: rtl/uart_frame_scheduler_rr_arbiter2.sv
// rtl/uart_frame_scheduler_rr_arbiter2.sv - two-way round-robin grant with priority pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant = 2'b00;
        if (!prio_q) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
        // Pointer moves to whichever requester was not just served.
        prio_d = prio_q;
        if (advance && (grant != 2'b00)) prio_d = grant[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) prio_q <= 1'b0;
        else      prio_q <= prio_d;
    end
endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - frames 32-bit words from two requesters into 7-byte UART frames
module uart_frame_scheduler
    import uart_frame_scheduler_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_scheduler_if.slave  bus
);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [2:0]       state_q, state_d;
    byte_idx_t        idx_q, idx_d;
    logic [7:0]       id_q, id_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tx_start;
    logic [1:0]       grant;
    byte_idx_t        nxt_idx;
    logic [7:0]       nxt_byte;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.req1_valid, bus.req0_valid}),
        .advance (state_q == ST_IDLE),
        .grant   (grant)
    );

    assign nxt_idx = idx_q + 3'd1;

    always_comb begin
        case (nxt_idx)
            3'd1:    nxt_byte = id_q;
            3'd2:    nxt_byte = data_q[31:24];
            3'd3:    nxt_byte = data_q[23:16];
            3'd4:    nxt_byte = data_q[15:8];
            3'd5:    nxt_byte = data_q[7:0];
            3'd6:    nxt_byte = chk_q;
            default: nxt_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        id_d      = id_q;
        data_d    = data_q;
        chk_d     = chk_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        tx_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = grant[1] ? ID_REQ1 : ID_REQ0;
                    data_d  = grant[1] ? bus.req1_data : bus.req0_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d     = '0;
                tx_data_d = SYNC_BYTE;
                chk_d     = frame_checksum(id_q, data_q);
                state_d   = ST_START;
            end
            ST_START: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == byte_idx_t'(FRAME_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d     = nxt_idx;
                    tx_data_d = nxt_byte;
                    state_d   = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            id_q      <= 8'h00;
            data_q    <= 32'h0;
            chk_q     <= 8'h00;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.req0_ready  = (state_q == ST_IDLE) && grant[0];
    assign bus.req1_ready  = (state_q == ST_IDLE) && grant[1];
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start;
    assign bus.frame_busy  = (state_q != ST_IDLE);
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_frame_scheduler_if u ();

    uart_frame_scheduler #(.SYNC_BYTE(8'hA5), .ACK_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] busy_cnt;
    logic       acc0, acc1;
    logic [7:0] log_q[$];
    int         grant_q[$];
    int         start_total = 0;
    int         ignore_until = 0;
    logic       drop0, drop1;

    // UART transmitter and requester-side observer
    always @(posedge clk) begin
        acc0 <= rst && u.req0_valid && u.req0_ready;
        acc1 <= rst && u.req1_valid && u.req1_ready;
        if (!rst) begin
            u.tx_busy <= 1'b0;
            busy_cnt  <= 2'd0;
        end else begin
            if (u.req0_valid && u.req0_ready) grant_q.push_back(0);
            if (u.req1_valid && u.req1_ready) grant_q.push_back(1);
            if (u.tx_start) start_total <= start_total + 1;
            if (u.tx_busy) begin
                if (busy_cnt == 2'd0) u.tx_busy <= 1'b0;
                else                  busy_cnt  <= busy_cnt - 2'd1;
            end else if (u.tx_start && start_total >= ignore_until) begin
                log_q.push_back(u.tx_data);
                u.tx_busy <= 1'b1;
                busy_cnt  <= 2'd2;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0 && drop0) u.req0_valid = 1'b0;
        if (acc1 && drop1) u.req1_valid = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int target);
        int n;
        n = 0;
        while (log_q.size() < target && n < 3000) begin tick(); n++; end
        check(tag, log_q.size(), target);
        n = 0;
        while (u.frame_busy && n < 100) begin tick(); n++; end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int base, gb, n, fb_gap, st0, t, sz, sc;
        logic [7:0] exp34 [7];
        exp34 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        u.req0_valid = 1'b0;
        u.req1_valid = 1'b0;
        u.req0_data  = 32'h0;
        u.req1_data  = 32'h0;
        drop0 = 1'b1;
        drop1 = 1'b1;

        rst = 1'b0;
        repeat (3) tick();
        check("rst_tx_start", u.tx_start, 1'b0);
        check("rst_tx_data", u.tx_data, 8'h00);
        check("rst_frame_busy", u.frame_busy, 1'b0);
        check("rst_err", u.err_timeout, 1'b0);
        check("rst_ready0", u.req0_ready, 1'b0);
        check("rst_ready1", u.req1_ready, 1'b0);
        rst = 1'b1;
        tick();

        // single frame from req0
        base = log_q.size(); gb = grant_q.size();
        u.req0_data = 32'h12345678; u.req0_valid = 1'b1;
        fb_gap = 0; n = 0;
        while (log_q.size() < base + 7 && n < 1000) begin
            tick(); n++;
            if (grant_q.size() > gb && !u.frame_busy) fb_gap++;
        end
        check("f1_len", log_q.size(), base + 7);
        for (int k = 0; k < 7; k++) check($sformatf("f1_byte%0d", k), log_q[base + k], exp34[k]);
        check("f1_grants", grant_q.size() - gb, 1);
        check("f1_busy_gap", fb_gap, 0);
        n = 0;
        while (u.frame_busy && n < 100) begin tick(); n++; end
        check("f1_busy_end", u.frame_busy, 1'b0);

        // simultaneous requests right after reset
        reset_pulse();
        base = log_q.size(); gb = grant_q.size();
        u.req0_data = 32'h0; u.req1_data = 32'hFFFFFFFF;
        u.req0_valid = 1'b1; u.req1_valid = 1'b1;
        wait_bytes("f2_len", base + 14);
        check("f2_grant_a", grant_q[gb], 0);
        check("f2_grant_b", grant_q[gb + 1], 1);
        check("f2_id_a", log_q[base + 1], 8'h00);
        check("f2_chk_a", log_q[base + 6], 8'h00);
        check("f2_sync_b", log_q[base + 7], 8'hA5);
        check("f2_id_b", log_q[base + 8], 8'h01);
        check("f2_chk_b", log_q[base + 13], 8'h01);

        // req0 held continuously, req1 arrives mid-frame
        base = log_q.size(); gb = grant_q.size();
        drop0 = 1'b0;
        u.req0_data = 32'hCAFEF00D; u.req0_valid = 1'b1;
        n = 0;
        while (grant_q.size() == gb && n < 100) begin tick(); n++; end
        repeat (10) tick();
        u.req1_data = 32'h0BADBEEF; u.req1_valid = 1'b1;
        n = 0;
        while (grant_q.size() < gb + 3 && n < 2000) begin tick(); n++; end
        u.req0_valid = 1'b0; drop0 = 1'b1;
        wait_bytes("f3_len", base + 21);
        check("f3_ngrants", grant_q.size() - gb, 3);
        check("f3_order0", grant_q[gb], 0);
        check("f3_order1", grant_q[gb + 1], 1);
        check("f3_order2", grant_q[gb + 2], 0);
        check("f3_id_mid", log_q[base + 8], 8'h01);
        check("f3_id_last", log_q[base + 15], 8'h00);

        // first start pulse is ignored by the transmitter
        base = log_q.size();
        st0 = start_total;
        ignore_until = start_total + 1;
        u.req0_data = 32'hA1B2C3D4; u.req0_valid = 1'b1;
        n = 0;
        while (start_total == st0 && n < 200) begin tick(); n++; end
        t = 0;
        while (!u.err_timeout && t < 100) begin tick(); t++; end
        check("to_latency", t, 15);
        check("to_err", u.err_timeout, 1'b1);
        wait_bytes("to_len", base + 7);
        check("to_first", log_q[base], 8'hA5);
        check("to_chk", log_q[base + 6], 8'h04);
        check("to_starts", start_total - st0, 8);
        check("to_sticky", u.err_timeout, 1'b1);

        // reset during byte 3, then a fresh req1 frame
        base = log_q.size();
        u.req0_data = 32'h55AA55AA; u.req0_valid = 1'b1;
        n = 0;
        while (log_q.size() < base + 3 && n < 1000) begin tick(); n++; end
        rst = 1'b0;
        tick();
        check("mr_tx_start", u.tx_start, 1'b0);
        check("mr_frame_busy", u.frame_busy, 1'b0);
        check("mr_ready0", u.req0_ready, 1'b0);
        check("mr_ready1", u.req1_ready, 1'b0);
        check("mr_err", u.err_timeout, 1'b0);
        check("mr_tx_data", u.tx_data, 8'h00);
        rst = 1'b1;
        sz = log_q.size(); sc = start_total;
        repeat (20) tick();
        check("mr_no_bytes", log_q.size(), sz);
        check("mr_no_starts", start_total, sc);
        base = log_q.size();
        u.req1_data = 32'h01020304; u.req1_valid = 1'b1;
        wait_bytes("mr_len", base + 7);
        check("mr_sync", log_q[base], 8'hA5);
        check("mr_id", log_q[base + 1], 8'h01);
        check("mr_chk", log_q[base + 6], 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
